// File: rtl/raster_counter.sv
// Purpose : raster scan coordinate generator (column, row, frame) for the image pipeline.
// Latency : coordinates and strobes are registered; they reflect an enabled cycle one clock later.
// Backpressure: count_enable low freezes the raster; strobes never stretch while stalled.
//
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-high reset
//   clear               - synchronous abort back to IDLE (beats start and count_enable)
//   start, single_shot  - begin a frame sequence from IDLE/DONE; single_shot selects one frame vs continuous
//   count_enable        - advance one pixel per cycle while running
//   col_max, row_max    - inclusive limits, captured at start and at every frame wrap
//   col_out, row_out    - current coordinates
//   frame_count         - frames completed since start (wraps)
//   line_done, frame_done - one-cycle strobes following a column / frame wrap
//   busy, done          - decoded RUN / DONE state
module raster_counter #(
    parameter int COL_BITS   = 10,
    parameter int ROW_BITS   = 10,
    parameter int FRAME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  count_enable,
    input  logic                  single_shot,
    input  logic [COL_BITS-1:0]   col_max,
    input  logic [ROW_BITS-1:0]   row_max,
    output logic [COL_BITS-1:0]   col_out,
    output logic [ROW_BITS-1:0]   row_out,
    output logic [FRAME_BITS-1:0] frame_count,
    output logic                  line_done,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [COL_BITS-1:0]     col_q;
    logic [ROW_BITS-1:0]     row_q;
    logic [FRAME_BITS-1:0]   frame_q;
    logic                    line_done_q;
    logic                    frame_done_q;
    // Shadow copies of the limits and mode; the live inputs may change mid-frame.
    logic [COL_BITS-1:0]     col_lim_q;
    logic [ROW_BITS-1:0]     row_lim_q;
    logic                    single_q;

    logic                    col_wrap_d;
    logic                    row_wrap_d;
    logic [COL_BITS-1:0]     col_inc_d;
    logic [ROW_BITS-1:0]     row_inc_d;
    logic [FRAME_BITS-1:0]   frame_inc_d;

    assign col_wrap_d  = (col_q == col_lim_q);
    assign row_wrap_d  = (row_q == row_lim_q);
    assign col_inc_d   = col_q + COL_BITS'(1);
    assign row_inc_d   = row_q + ROW_BITS'(1);
    assign frame_inc_d = frame_q + FRAME_BITS'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            frame_q      <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            col_lim_q    <= '0;
            row_lim_q    <= '0;
            single_q     <= 1'b0;
        end else begin
            // Strobes default low so they are exactly one cycle wide.
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (clear) begin
                state_q <= S_IDLE;
                col_q   <= '0;
                row_q   <= '0;
                frame_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state_q   <= S_RUN;
                            col_lim_q <= col_max;
                            row_lim_q <= row_max;
                            single_q  <= single_shot;
                            col_q     <= '0;
                            row_q     <= '0;
                            frame_q   <= '0;
                        end
                    end
                    S_RUN: begin
                        if (count_enable) begin
                            if (!col_wrap_d) begin
                                col_q <= col_inc_d;
                            end else begin
                                col_q       <= '0;
                                line_done_q <= 1'b1;
                                if (!row_wrap_d) begin
                                    row_q <= row_inc_d;
                                end else begin
                                    row_q        <= '0;
                                    frame_done_q <= 1'b1;
                                    frame_q      <= frame_inc_d;
                                    if (single_q) begin
                                        state_q <= S_DONE;
                                    end else begin
                                        // Continuous: next frame uses the limits present now.
                                        col_lim_q <= col_max;
                                        row_lim_q <= row_max;
                                    end
                                end
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign col_out     = col_q;
    assign row_out     = row_q;
    assign frame_count = frame_q;
    assign line_done   = line_done_q;
    assign frame_done  = frame_done_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_raster_counter.sv
module tb_raster_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       count_enable = 1'b0;
    logic       single_shot = 1'b0;
    logic [9:0] col_max = '0;
    logic [9:0] row_max = '0;
    logic [9:0] col_out;
    logic [9:0] row_out;
    logic [7:0] frame_count;
    logic       line_done, frame_done, busy, done;

    // Narrow-frame-counter instance sharing the same stimulus.
    logic [9:0] col_out2;
    logic [9:0] row_out2;
    logic [1:0] frame_count2;
    logic       line_done2, frame_done2, busy2, done2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    raster_counter #(.COL_BITS(10), .ROW_BITS(10), .FRAME_BITS(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start),
        .count_enable(count_enable), .single_shot(single_shot),
        .col_max(col_max), .row_max(row_max),
        .col_out(col_out), .row_out(row_out), .frame_count(frame_count),
        .line_done(line_done), .frame_done(frame_done), .busy(busy), .done(done)
    );

    raster_counter #(.COL_BITS(10), .ROW_BITS(10), .FRAME_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .start(start),
        .count_enable(count_enable), .single_shot(single_shot),
        .col_max(col_max), .row_max(row_max),
        .col_out(col_out2), .row_out(row_out2), .frame_count(frame_count2),
        .line_done(line_done2), .frame_done(frame_done2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the active edge; inputs are changed at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int c, input int r, input int f,
                           input bit ld, input bit fd, input bit b, input bit d);
        chk({tag, ".col"}, 32'(col_out), 32'(c));
        chk({tag, ".row"}, 32'(row_out), 32'(r));
        chk({tag, ".frame"}, 32'(frame_count), 32'(f));
        chk({tag, ".line_done"}, 32'(line_done), 32'(ld));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    initial begin
        int ec[6];
        int er[6];
        bit [8:0] gap_ce;
        int gc[9];
        int gr[9];
        int f2[5];

        // ---------------- reset ----------------
        #3;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        // ---------------- single shot 4x2 ----------------
        col_max = 10'd3; row_max = 10'd1; single_shot = 1'b1;
        start = 1'b1; count_enable = 1'b1;
        tick();
        start = 1'b0;
        chk_all("ss_start", 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk_all($sformatf("ss_en%0d", i), i % 4, (i >= 4 && i < 8) ? 1 : 0,
                    (i == 8) ? 1 : 0, (i == 4 || i == 8), (i == 8), (i != 8), (i == 8));
        end
        tick();
        chk_all("ss_after", 0, 0, 1, 0, 0, 0, 1);

        // ---------------- continuous 2x2, 12 enables ----------------
        col_max = 10'd1; row_max = 10'd1; single_shot = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("ct_start", 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            start = (i == 5);  // start while running must be ignored
            tick();
            chk_all($sformatf("ct_en%0d", i), i % 2, ((i % 4) == 2 || (i % 4) == 3) ? 1 : 0,
                    i / 4, (i % 2) == 0, (i % 4) == 0, 1, 0);
        end
        start = 1'b0;

        // ---------------- limit change mid-frame ----------------
        clear = 1'b1;
        tick();
        chk_all("lc_clear", 0, 0, 0, 0, 0, 0, 0);
        clear = 1'b0; start = 1'b1; col_max = 10'd1; row_max = 10'd1;
        tick();
        start = 1'b0;
        ec = '{1, 0, 1, 0, 1, 2};
        er = '{0, 1, 1, 0, 0, 0};
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk_all($sformatf("lc_en%0d", i), ec[i-1], er[i-1], (i >= 4) ? 1 : 0,
                    (i == 2 || i == 4), (i == 4), 1, 0);
            if (i == 2) col_max = 10'd2;
        end

        // ---------------- gapped enable ----------------
        clear = 1'b1;
        tick();
        clear = 1'b0; start = 1'b1; col_max = 10'd2; row_max = 10'd3; count_enable = 1'b0;
        tick();
        start = 1'b0;
        gap_ce = 9'b001001001;  // bit k-1 = enable at cycle k
        gc = '{1, 1, 1, 2, 2, 2, 0, 0, 0};
        gr = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        for (int k = 1; k <= 9; k++) begin
            count_enable = gap_ce[k-1];
            tick();
            chk_all($sformatf("gap_c%0d", k), gc[k-1], gr[k-1], 0, (k == 7), 0, 1, 0);
        end

        // ---------------- both limits zero ----------------
        clear = 1'b1;
        tick();
        clear = 1'b0; start = 1'b1; col_max = 10'd0; row_max = 10'd0; count_enable = 1'b0;
        tick();
        start = 1'b0; count_enable = 1'b1;
        f2 = '{1, 2, 3, 0, 1};
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all($sformatf("z_en%0d", i), 0, 0, i, 1, 1, 1, 0);
            chk($sformatf("z_en%0d.frame2", i), 32'(frame_count2), 32'(f2[i-1]));
        end
        count_enable = 1'b0;
        tick();
        chk_all("z_hold", 0, 0, 5, 0, 0, 1, 0);

        // ---------------- clear mid-frame with coincident start ----------------
        clear = 1'b1;
        tick();
        clear = 1'b0; start = 1'b1; col_max = 10'd3; row_max = 10'd3; count_enable = 1'b0;
        tick();
        start = 1'b0; count_enable = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        chk_all("ab_pre", 2, 1, 0, 0, 0, 1, 0);
        clear = 1'b1; start = 1'b1;
        tick();
        chk_all("ab_clear", 0, 0, 0, 0, 0, 0, 0);
        clear = 1'b0; start = 1'b0;
        tick();
        chk_all("ab_idle", 0, 0, 0, 0, 0, 0, 0);

        // ---------------- async reset mid-frame ----------------
        start = 1'b1; col_max = 10'd2; row_max = 10'd3; count_enable = 1'b0;
        tick();
        start = 1'b0; count_enable = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        chk_all("rs_pre", 2, 1, 0, 0, 0, 1, 0);
        #1 rst = 1'b1;  // next enabled edge would have wrapped the column
        #1;
        chk_all("rs_async", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_all("rs_release", 0, 0, 0, 0, 0, 0, 0);
        count_enable = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/raster_counter.md
Name: raster_counter

Overview:
- Parametrised successor to the single-dimension flex counter: two cascaded counters (column, row) plus a frame counter generate raster scan coordinates for the image pipeline.
- It feeds pixel/line addressing to the window buffers and edge filters.
- Limits are programmable and latched at frame start.
- Adds start/done sequencing, a single-shot or continuous mode, and registered line and frame strobes.

Parameters:
- COL_BITS, 10, width of the column counter and col_max.
- ROW_BITS, 10, width of the row counter and row_max.
- FRAME_BITS, 8, width of the frame counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; returns the block to IDLE.
- start  input  1  begins a frame sequence when sampled in IDLE or DONE.
- count_enable  input  1  advances the raster by one pixel per cycle while RUN.
- single_shot  input  1  sampled with start: 1 = stop after one frame, 0 = continuous.
- col_max  input  COL_BITS  last column index (inclusive), sampled at start and at each frame wrap.
- row_max  input  ROW_BITS  last row index (inclusive), sampled at the same points.
- col_out  output  COL_BITS  current column.
- row_out  output  ROW_BITS  current row.
- frame_count  output  FRAME_BITS  completed frames since start, modulo 2^FRAME_BITS.
- line_done  output  1  one-cycle pulse after a column wrap.
- frame_done  output  1  one-cycle pulse after the final pixel of a frame.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE; col_out=0, row_out=0, frame_count=0, line_done=0, frame_done=0, busy=0, done=0; shadow limits=0; mode latch=0.
- Priority: rst > clear > start > count_enable.
- States: IDLE, RUN, DONE. All outputs are registered; busy = (state==RUN) and done = (state==DONE) are decoded from the state register.
- IDLE:
  - start=1 → RUN next cycle.
  - Latch col_max, row_max and single_shot into shadow registers.
  - Clear col_out, row_out and frame_count to 0.
- RUN, count_enable=0: all counters hold; strobes 0.
- RUN, count_enable=1:
  - col_out != col_lim: col_out+1.
  - col_out == col_lim: col_out←0 and line_done=1 next cycle; then:
    - row_out != row_lim: row_out+1.
    - row_out == row_lim: row_out←0, frame_done=1 next cycle (coincident with line_done), frame_count+1 (wraps to 0 past all-ones).
    - If the latched mode is single-shot: go to DONE.
    - Otherwise: stay in RUN and re-sample col_max/row_max into the shadow registers in the same cycle.
- RUN, start=1: ignored, no relatch.
- DONE:
  - Counters hold at 0/0; frame_count holds.
  - start=1 → RUN with a fresh latch and frame_count cleared.
- clear=1 in any state:
  - Next cycle: IDLE, col/row/frame_count=0, strobes 0.
  - clear overrides a coincident start or count_enable.
- Limits of 0 are legal:
  - col_max=0: every enabled cycle wraps the column.
  - col_max=0 and row_max=0: every enabled cycle produces line_done and frame_done.
- Changes on col_max/row_max mid-frame have no effect until the next frame wrap or start.
- Strobes are exactly one cycle wide and never held by count_enable=0.
- rst asserted mid-frame forces all reset values immediately, with no pending strobe emitted after release.

Test Plan:
- Reset then start, col_max=3, row_max=1, single_shot=1, count_enable=1 continuously:
  - col_out sequence 0,1,2,3,0,1,2,3.
  - row_out goes 0→1 on the 4th enable.
  - line_done pulses after enable 4 and enable 8.
  - frame_done pulses once after enable 8; frame_count=1.
  - done=1, busy=0, coordinates 0/0 thereafter.
- Continuous mode, col_max=1, row_max=1, 12 enables:
  - frame_done pulses after enables 4, 8 and 12; frame_count=3.
  - col_max changed to 2 after enable 2 takes effect only from enable 5.
- Gapped enable (1,0,0,1,…) with col_max=2:
  - Counters hold on idle cycles.
  - line_done appears only on the cycle after the 3rd enabled cycle, one cycle wide.
- Both limits 0, continuous, 5 enables:
  - line_done and frame_done high for 5 consecutive cycles.
  - frame_count=5; col_out and row_out stay 0.
- Mid-frame abort:
  - clear at col=2, row=1 → IDLE next cycle, all outputs 0, a coincident start ignored.
  - rst pulse asserted between clock edges at col=2, row=1 → outputs reach 0 before the next edge.
- FRAME_BITS=2, continuous, 5 frames: frame_count sequence 1,2,3,0,1.
